// File: rtl/mem_hs_ctl_pkg.sv
// Shared types and default widths for the four-phase handshake memory controller.
package mem_hs_ctl_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefToCyc = 16;
  localparam int unsigned DefCntW  = 8;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StWStb  = 4'd1,
    StWRel  = 4'd2,
    StWAck  = 4'd3,
    StRStb  = 4'd4,
    StRAck  = 4'd5,
    StRDout = 4'd6,
    StRDrel = 4'd7,
    StRRel  = 4'd8
  } state_e;

endpackage

// File: rtl/mem_hs_ctl_if.sv
// Host and memory handshake bundle; master = controller view, slave = host/memory view.
interface mem_hs_ctl_if import mem_hs_ctl_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW
);
  logic              wen;
  logic              din_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              din_ack;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ack;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  xfer_cnt;

  modport master (
    input  wen, din_valid, addr, din, dout_ack, mem_rdata, mem_done,
    output din_ack, dout, dout_valid, write, read, mem_addr, mem_wdata, busy, err, xfer_cnt
  );

  modport slave (
    output wen, din_valid, addr, din, dout_ack, mem_rdata, mem_done,
    input  din_ack, dout, dout_valid, write, read, mem_addr, mem_wdata, busy, err, xfer_cnt
  );
endinterface

// File: rtl/mem_hs_timer.sv
// Down-counter that reloads to Cycles-1 on load_i and flags expiry when it reaches zero.
module mem_hs_timer #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= LoadVal;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/mem_hs_ctl.sv
// Four-phase host <-> synchronous-handshake memory controller with a transfer counter.
// Define MEM_HS_CTL_TIMEOUT_EN to add memory-side timeout detection and recovery.
module mem_hs_ctl import mem_hs_ctl_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
`ifdef MEM_HS_CTL_TIMEOUT_EN
  parameter int unsigned TO_CYC = DefToCyc,
`endif
  parameter int unsigned CNT_W  = DefCntW
) (
  input logic           clk,
  input logic           rst,
  mem_hs_ctl_if.master  bus
);
  state_e            state_d, state_q;
  logic              write_d, write_q, read_d, read_q;
  logic              din_ack_d, din_ack_q, dout_valid_d, dout_valid_q;
  logic              err_d, err_q, busy_q, tmo;
  logic [DATA_W-1:0] dout_d, dout_q, mem_wdata_d, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

`ifdef MEM_HS_CTL_TIMEOUT_EN
  mem_hs_timer #(
    .Cycles (TO_CYC)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (state_d != state_q),
    .en_i     (busy_q),
    .expire_o (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.din_valid) state_d = bus.wen ? StWStb : StRStb;
      StWStb:  if (bus.mem_done) state_d = StWRel;
               else if (tmo)     state_d = StWAck;
      StWRel:  if (!bus.mem_done || tmo) state_d = StWAck;
      StWAck:  if (!bus.din_valid) state_d = StIdle;
      StRStb:  if (bus.mem_done || tmo) state_d = StRAck;
      StRAck:  if (!bus.din_valid) state_d = StRDout;
      StRDout: if (bus.dout_ack) state_d = StRDrel;
      StRDrel: if (!bus.dout_ack) state_d = StRRel;
      StRRel:  if (!bus.mem_done || tmo) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A real mem_done edge always takes priority over an expiry in the same cycle.
  always_comb begin
    write_d      = write_q;
    read_d       = read_q;
    din_ack_d    = din_ack_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: if (bus.din_valid) begin
        mem_addr_d  = bus.addr;
        mem_wdata_d = bus.din;
        err_d       = 1'b0;
        write_d     = bus.wen;
        read_d      = ~bus.wen;
      end
      StWStb: if (bus.mem_done) begin
        write_d = 1'b0;
      end else if (tmo) begin
        write_d   = 1'b0;
        err_d     = 1'b1;
        din_ack_d = 1'b1;
      end
      StWRel: if (!bus.mem_done) begin
        din_ack_d = 1'b1;
      end else if (tmo) begin
        err_d     = 1'b1;
        din_ack_d = 1'b1;
      end
      StWAck: if (!bus.din_valid) begin
        din_ack_d = 1'b0;
        if (!err_q) cnt_d = cnt_q + CNT_W'(1);
      end
      StRStb: if (bus.mem_done) begin
        dout_d    = bus.mem_rdata;
        din_ack_d = 1'b1;
      end else if (tmo) begin
        dout_d    = '0;
        din_ack_d = 1'b1;
        read_d    = 1'b0;
        err_d     = 1'b1;
      end
      StRAck: if (!bus.din_valid) begin
        din_ack_d    = 1'b0;
        dout_valid_d = 1'b1;
      end
      StRDout: if (bus.dout_ack) dout_valid_d = 1'b0;
      StRDrel: if (!bus.dout_ack) read_d = 1'b0;
      StRRel: if (!bus.mem_done) begin
        if (!err_q) cnt_d = cnt_q + CNT_W'(1);
      end else if (tmo) begin
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      din_ack_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      write_q      <= write_d;
      read_q       <= read_d;
      din_ack_q    <= din_ack_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign bus.write      = write_q;
  assign bus.read       = read_q;
  assign bus.din_ack    = din_ack_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.err        = err_q;
  assign bus.xfer_cnt   = cnt_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_hs_ctl.sv
// Directed bench for mem_hs_ctl: host tasks, a 3-cycle memory responder and a scoreboard queue.
module tb_mem_hs_ctl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_hs_ctl_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(2)) bus ();

  mem_hs_ctl #(
    .DATA_W (8),
    .ADDR_W (4),
`ifdef MEM_HS_CTL_TIMEOUT_EN
    .TO_CYC (4),
`endif
    .CNT_W  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_cnt = 2'd0;

  // Memory responder: raises mem_done 3 cycles after a strobe, drops it after the strobe falls.
  logic       mem_ack = 1'b0;
  logic       mem_mute = 1'b0;
  logic       spur = 1'b0;
  logic [7:0] rd_val = 8'h00;
  int         mem_dly = 0;
  assign bus.mem_done  = mem_ack | spur;
  assign bus.mem_rdata = rd_val;

  always @(posedge clk) begin
    #1;
    if (!rst || !(bus.write || bus.read)) begin
      mem_ack = 1'b0;
      mem_dly = 0;
    end else if (!mem_ack && !mem_mute) begin
      mem_dly++;
      if (mem_dly == 3) mem_ack = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!bus.din_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    sb_t e;
    int  n;
    sb_q.push_back('{wr: 1'b1, addr: a, data: d});
    @(negedge clk);
    bus.addr = a; bus.din = d; bus.wen = 1'b1; bus.din_valid = 1'b1;
    @(negedge clk);
    e = sb_q.pop_front();
    check("wr_strobe", bus.write, 1);
    check("wr_addr", bus.mem_addr, e.addr);
    check("wr_data", bus.mem_wdata, e.data);
    check("wr_err_clr", bus.err, 0);
    check("wr_busy", bus.busy, 1);
    wait_ack(n);
    check("wr_ack_lat", n, 4);
    check("wr_strobe_off", bus.write, 0);
    check("wr_done_low", bus.mem_done, 0);
    bus.din_valid = 1'b0;
    @(negedge clk);
    exp_cnt++;
    check("wr_ack_drop", bus.din_ack, 0);
    check("wr_idle", bus.busy, 0);
    check("wr_cnt", bus.xfer_cnt, exp_cnt);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] rd, input bit mute);
    sb_t e;
    int  n;
    sb_q.push_back('{wr: 1'b0, addr: a, data: mute ? 8'h00 : rd});
    rd_val = rd; mem_mute = mute;
    @(negedge clk);
    bus.addr = a; bus.wen = 1'b0; bus.din_valid = 1'b1;
    @(negedge clk);
    e = sb_q.pop_front();
    check("rd_strobe", bus.read, 1);
    check("rd_no_wr", bus.write, 0);
    check("rd_addr", bus.mem_addr, e.addr);
    check("rd_err_clr", bus.err, 0);
    wait_ack(n);
    check("rd_ack_lat", n, mute ? 4 : 3);
    check("rd_strobe_at_ack", bus.read, !mute);
    check("rd_err", bus.err, mute);
    check("rd_dout", bus.dout, e.data);
    check("rd_no_dvalid", bus.dout_valid, 0);
    bus.din_valid = 1'b0;
    @(negedge clk);
    check("rd_ack_drop", bus.din_ack, 0);
    check("rd_dvalid", bus.dout_valid, 1);
    check("rd_strobe_dv", bus.read, !mute);
    bus.dout_ack = 1'b1;
    @(negedge clk);
    check("rd_dvalid_drop", bus.dout_valid, 0);
    check("rd_strobe_dack", bus.read, !mute);
    bus.dout_ack = 1'b0;
    @(negedge clk);
    check("rd_strobe_rel", bus.read, 0);
    check("rd_busy_rel", bus.busy, 1);
    if (!mute) exp_cnt++;
    wait_idle(n);
    check("rd_idle_lat", n, 1);
    check("rd_cnt", bus.xfer_cnt, exp_cnt);
    check("rd_dout_held", bus.dout, e.data);
    mem_mute = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.wen = 1'b0; bus.din_valid = 1'b0; bus.addr = '0; bus.din = '0; bus.dout_ack = 1'b0;
    #12;
    check("rst_write", bus.write, 0);
    check("rst_read", bus.read, 0);
    check("rst_ack", bus.din_ack, 0);
    check("rst_dvalid", bus.dout_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_cnt", bus.xfer_cnt, 0);
    check("rst_dout", bus.dout, 0);
    @(negedge clk);
    rst = 1'b1;

    do_write(4'd3, 8'hA5);
    do_read(4'd3, 8'h5A, 1'b0);
    do_read(4'd9, 8'hC3, 1'b0);

    // Reset while the host holds read data
    rd_val = 8'h3C;
    @(negedge clk);
    bus.addr = 4'd5; bus.wen = 1'b0; bus.din_valid = 1'b1;
    @(negedge clk);
    wait_ack(n);
    check("mr_ack", bus.din_ack, 1);
    bus.din_valid = 1'b0;
    @(negedge clk);
    check("mr_dvalid", bus.dout_valid, 1);
    check("mr_cnt_before", bus.xfer_cnt, 3);
    rst = 1'b0;
    #1;
    check("mr_read", bus.read, 0);
    check("mr_write", bus.write, 0);
    check("mr_ack_off", bus.din_ack, 0);
    check("mr_dvalid_off", bus.dout_valid, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_cnt", bus.xfer_cnt, 0);
    check("mr_dout", bus.dout, 0);
    check("mr_addr", bus.mem_addr, 0);
    exp_cnt = 2'd0;
    @(negedge clk);
    rst = 1'b1;

    // Five writes: counter walks 1,2,3,0,1
    do_write(4'd1, 8'h11);
    do_write(4'd2, 8'h22);
    do_write(4'd4, 8'h44);
    do_write(4'd8, 8'h88);
    do_write(4'd15, 8'hF0);

    // Spurious mem_done pulse in IDLE
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("sp_write", bus.write, 0);
    check("sp_read", bus.read, 0);
    check("sp_ack", bus.din_ack, 0);
    check("sp_busy", bus.busy, 0);
    check("sp_cnt", bus.xfer_cnt, exp_cnt);
    check("sp_addr", bus.mem_addr, 4'd15);

`ifdef MEM_HS_CTL_TIMEOUT_EN
    do_read(4'd7, 8'hEE, 1'b1);
    check("to_err_sticky", bus.err, 1);
    do_write(4'd6, 8'h66);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
